// File: rtl/multi_xfer_sequencer.sv
// rtl/multi_xfer_sequencer.sv - LM/SM cracker: one single-register transfer micro-op per set mask bit
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   ir_in, ir_valid     instruction in IF/ID and its valid qualifier
//   stall, flush        downstream hold / abort (flush wins over stall)
//   uop_valid .. uop_last  registered micro-op fields for the ID IR_load_mux
//   nop_mask            one-cycle pulse when an LM/SM with an empty mask is consumed
//   pc_write, ifid_hold combinational fetch / IF/ID control (ifid_hold = ~pc_write)
//   busy                sequence in progress
module multi_xfer_sequencer #(
    parameter int          IR_W     = 16,
    parameter int          NUM_REGS = 8,
    parameter int          REG_AW   = 3,
    parameter logic [3:0]  OP_LM    = 4'b0110,
    parameter logic [3:0]  OP_SM    = 4'b0111,
    parameter bit          ORDER    = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IR_W-1:0]   ir_in,
    input  logic              ir_valid,
    input  logic              stall,
    input  logic              flush,
    output logic              uop_valid,
    output logic [REG_AW-1:0] uop_reg,
    output logic [2:0]        uop_base,
    output logic [REG_AW:0]   uop_offset,
    output logic              uop_store,
    output logic              uop_first,
    output logic              uop_last,
    output logic              nop_mask,
    output logic              pc_write,
    output logic              ifid_hold,
    output logic              busy
);

    typedef enum logic [0:0] {IDLE = 1'b0, SEQ = 1'b1} state_t;

    state_t              state, state_d;
    logic [NUM_REGS-1:0] rem, rem_d;

    logic              uop_valid_d, uop_store_d, uop_first_d, uop_last_d, nop_mask_d;
    logic [REG_AW-1:0] uop_reg_d;
    logic [2:0]        uop_base_d;
    logic [REG_AW:0]   uop_offset_d;

    logic [3:0]          opcode;
    logic [NUM_REGS-1:0] mask;
    logic                is_lmsm;
    logic                multi;
    logic                seq_done;
    logic                accept;
    logic [REG_AW-1:0]   mask_idx, rem_idx;
    logic [NUM_REGS-1:0] mask_rest, rem_rest;
    logic                unused_ir;

    assign opcode    = ir_in[IR_W-1 -: 4];
    assign mask      = ir_in[NUM_REGS-1:0];
    assign is_lmsm   = (opcode == OP_LM) || (opcode == OP_SM);
    assign unused_ir = ^ir_in;

    // More than one set bit: the instruction must stay in IF/ID past this cycle.
    assign multi = (mask & (mask - NUM_REGS'(1))) != '0;

    // The last micro-op is on display and nothing remains: the instruction now in
    // IF/ID is already the next one, so it may be accepted back-to-back.
    assign seq_done = (state == SEQ) && (rem == '0) && uop_last;

    // Gated by reset so pc_write stays high while reset is held.
    assign accept = !reset && ir_valid && is_lmsm && !stall && !flush &&
                    ((state == IDLE) || seq_done);

    // Next register in issue order: last match wins, so scan direction picks
    // lowest (ascending) or highest (descending) set bit.
    function automatic logic [REG_AW-1:0] pick_idx(input logic [NUM_REGS-1:0] m);
        logic [REG_AW-1:0] idx;
        idx = '0;
        if (ORDER == 1'b0) begin
            for (int i = NUM_REGS-1; i >= 0; i--)
                if (m[i]) idx = REG_AW'(i);
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (m[i]) idx = REG_AW'(i);
        end
        return idx;
    endfunction

    assign mask_idx  = pick_idx(mask);
    assign mask_rest = mask & ~(NUM_REGS'(1) << mask_idx);
    assign rem_idx   = pick_idx(rem);
    assign rem_rest  = rem & ~(NUM_REGS'(1) << rem_idx);

    // Multi-register accept (from IDLE or back-to-back) also holds fetch.
    assign pc_write  = !((accept && multi) || ((state == SEQ) && (rem != '0)));
    assign ifid_hold = !pc_write;
    assign busy      = (state == SEQ);

    always_comb begin
        state_d      = state;
        rem_d        = rem;
        uop_valid_d  = uop_valid;
        uop_reg_d    = uop_reg;
        uop_base_d   = uop_base;
        uop_offset_d = uop_offset;
        uop_store_d  = uop_store;
        uop_first_d  = uop_first;
        uop_last_d   = uop_last;
        nop_mask_d   = nop_mask;

        if (flush) begin
            state_d     = IDLE;
            rem_d       = '0;
            uop_valid_d = 1'b0;
            uop_first_d = 1'b0;
            uop_last_d  = 1'b0;
            nop_mask_d  = 1'b0;
        end else if (!stall) begin
            nop_mask_d = 1'b0;
            if (accept) begin
                uop_base_d  = ir_in[11:9];
                uop_store_d = (opcode == OP_SM);
                if (mask == '0) begin
                    nop_mask_d  = 1'b1;
                    uop_valid_d = 1'b0;
                    uop_first_d = 1'b0;
                    uop_last_d  = 1'b0;
                    rem_d       = '0;
                    state_d     = IDLE;
                end else begin
                    uop_valid_d  = 1'b1;
                    uop_first_d  = 1'b1;
                    uop_offset_d = '0;
                    uop_reg_d    = mask_idx;
                    rem_d        = mask_rest;
                    uop_last_d   = (mask_rest == '0);
                    state_d      = SEQ;
                end
            end else if (state == SEQ) begin
                if (rem != '0) begin
                    uop_reg_d    = rem_idx;
                    uop_offset_d = uop_offset + {{REG_AW{1'b0}}, 1'b1};
                    uop_first_d  = 1'b0;
                    rem_d        = rem_rest;
                    uop_last_d   = (rem_rest == '0);
                end else begin
                    uop_valid_d = 1'b0;
                    uop_first_d = 1'b0;
                    uop_last_d  = 1'b0;
                    state_d     = IDLE;
                end
            end else begin
                uop_valid_d = 1'b0;
                uop_first_d = 1'b0;
                uop_last_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rem        <= '0;
            uop_valid  <= 1'b0;
            uop_reg    <= '0;
            uop_base   <= '0;
            uop_offset <= '0;
            uop_store  <= 1'b0;
            uop_first  <= 1'b0;
            uop_last   <= 1'b0;
            nop_mask   <= 1'b0;
        end else begin
            state      <= state_d;
            rem        <= rem_d;
            uop_valid  <= uop_valid_d;
            uop_reg    <= uop_reg_d;
            uop_base   <= uop_base_d;
            uop_offset <= uop_offset_d;
            uop_store  <= uop_store_d;
            uop_first  <= uop_first_d;
            uop_last   <= uop_last_d;
            nop_mask   <= nop_mask_d;
        end
    end

endmodule

// File: tb/tb_multi_xfer_sequencer.sv
// tb/tb_multi_xfer_sequencer.sv - directed self-checking bench for multi_xfer_sequencer
module tb_multi_xfer_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ir_in;
    logic        ir_valid, stall, flush;

    logic       a_valid, a_store, a_first, a_last, a_nop, a_pcw, a_hold, a_busy;
    logic [2:0] a_reg, a_base;
    logic [3:0] a_off;
    logic       b_valid, b_store, b_first, b_last, b_nop, b_pcw, b_hold, b_busy;
    logic [2:0] b_reg, b_base;
    logic [3:0] b_off;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_xfer_sequencer #(.ORDER(1'b0)) dut0 (
        .clk(clk), .reset(reset), .ir_in(ir_in), .ir_valid(ir_valid),
        .stall(stall), .flush(flush),
        .uop_valid(a_valid), .uop_reg(a_reg), .uop_base(a_base), .uop_offset(a_off),
        .uop_store(a_store), .uop_first(a_first), .uop_last(a_last), .nop_mask(a_nop),
        .pc_write(a_pcw), .ifid_hold(a_hold), .busy(a_busy)
    );

    multi_xfer_sequencer #(.ORDER(1'b1)) dut1 (
        .clk(clk), .reset(reset), .ir_in(ir_in), .ir_valid(ir_valid),
        .stall(stall), .flush(flush),
        .uop_valid(b_valid), .uop_reg(b_reg), .uop_base(b_base), .uop_offset(b_off),
        .uop_store(b_store), .uop_first(b_first), .uop_last(b_last), .nop_mask(b_nop),
        .pc_write(b_pcw), .ifid_hold(b_hold), .busy(b_busy)
    );

    // Packed view: {valid, reg, offset, first, last, store, base, pc_write, busy}
    function automatic logic [15:0] pack(input logic v, input logic [2:0] r, input logic [3:0] o,
                                         input logic f, input logic l, input logic s,
                                         input logic [2:0] b, input logic p, input logic y);
        return {v, r, o, f, l, s, b, p, y};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] got;
        reset = 1'b1; ir_in = 16'h66A5; ir_valid = 1'b1; stall = 1'b0; flush = 1'b0;
        @(negedge clk);
        got = pack(a_valid, a_reg, a_off, a_first, a_last, a_store, a_base, a_pcw, a_busy);
        checks++;
        if (got !== 16'h0002) begin
            failures++;
            $display("FAIL reset_state got %h want %h", got, 16'h0002);
        end
        checks++;
        if ({a_hold, a_nop, b_hold, b_valid, b_pcw} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_misc got %b want 00001", {a_hold, a_nop, b_hold, b_valid, b_pcw});
        end
        next_cycle();
        reset = 1'b0; ir_valid = 1'b0;
    endtask

    task automatic test_lm_ascending();
        int exp_reg[4] = '{0, 2, 5, 7};
        logic [15:0] got, exp;
        next_cycle();
        ir_in = 16'h66A5; ir_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_pcw, a_hold, a_valid} !== 3'b010) begin
            failures++;
            $display("FAIL lm_asc_T got %b want 010", {a_pcw, a_hold, a_valid});
        end
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            if (k == 4) ir_valid = 1'b0;
            @(negedge clk);
            got = pack(a_valid, a_reg, a_off, a_first, a_last, a_store, a_base, a_pcw, a_busy);
            exp = pack(1'b1, 3'(exp_reg[k-1]), 4'(k-1), k == 1, k == 4, 1'b0, 3'd3, k == 4, 1'b1);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL lm_asc_T+%0d got %h want %h", k, got, exp);
            end
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({a_valid, a_busy, a_pcw} !== 3'b001) begin
            failures++;
            $display("FAIL lm_asc_end got %b want 001", {a_valid, a_busy, a_pcw});
        end
    endtask

    task automatic test_sm_descending();
        int exp_reg[4] = '{7, 5, 2, 0};
        logic [15:0] got, exp;
        next_cycle();
        ir_in = 16'h76A5; ir_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (b_pcw !== 1'b0) begin
            failures++;
            $display("FAIL sm_desc_T pc_write got %b want 0", b_pcw);
        end
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            if (k == 4) ir_valid = 1'b0;
            @(negedge clk);
            got = pack(b_valid, b_reg, b_off, b_first, b_last, b_store, b_base, b_pcw, b_busy);
            exp = pack(1'b1, 3'(exp_reg[k-1]), 4'(k-1), k == 1, k == 4, 1'b1, 3'd3, k == 4, 1'b1);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL sm_desc_T+%0d got %h want %h", k, got, exp);
            end
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({b_valid, b_busy} !== 2'b00) begin
            failures++;
            $display("FAIL sm_desc_end got %b want 00", {b_valid, b_busy});
        end
    endtask

    task automatic test_empty_mask();
        next_cycle();
        ir_in = 16'h6000; ir_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_pcw, a_busy, a_nop} !== 3'b100) begin
            failures++;
            $display("FAIL nop_T got %b want 100", {a_pcw, a_busy, a_nop});
        end
        next_cycle();
        ir_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_nop, a_valid, a_pcw, a_busy, b_nop} !== 5'b10101) begin
            failures++;
            $display("FAIL nop_pulse got %b want 10101", {a_nop, a_valid, a_pcw, a_busy, b_nop});
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({a_nop, a_valid, a_pcw, a_busy} !== 4'b0010) begin
            failures++;
            $display("FAIL nop_after got %b want 0010", {a_nop, a_valid, a_pcw, a_busy});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] got, exp;
        next_cycle();
        ir_in = 16'h6004; ir_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (a_pcw !== 1'b1) begin
            failures++;
            $display("FAIL b2b_single_pc got %b want 1", a_pcw);
        end
        next_cycle();
        ir_in = 16'h6003;
        @(negedge clk);
        got = pack(a_valid, a_reg, a_off, a_first, a_last, a_store, a_base, a_pcw, a_busy);
        exp = pack(1'b1, 3'd2, 4'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL b2b_first got %h want %h", got, exp);
        end
        next_cycle();
        @(negedge clk);
        got = pack(a_valid, a_reg, a_off, a_first, a_last, a_store, a_base, a_pcw, a_busy);
        exp = pack(1'b1, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL b2b_second_a got %h want %h", got, exp);
        end
        next_cycle();
        ir_valid = 1'b0;
        @(negedge clk);
        got = pack(a_valid, a_reg, a_off, a_first, a_last, a_store, a_base, a_pcw, a_busy);
        exp = pack(1'b1, 3'd1, 4'd1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL b2b_second_b got %h want %h", got, exp);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({a_valid, a_busy} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_end got %b want 00", {a_valid, a_busy});
        end
    endtask

    task automatic test_stall();
        next_cycle();
        ir_in = 16'h6006; ir_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (a_pcw !== 1'b0) begin
            failures++;
            $display("FAIL stall_T pc_write got %b want 0", a_pcw);
        end
        next_cycle();
        stall = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_valid, a_reg, a_first, a_last, a_pcw} !== {1'b1, 3'd1, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL stall_T+1 got %b want 1001100", {a_valid, a_reg, a_first, a_last, a_pcw});
        end
        next_cycle();
        stall = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_valid, a_reg, a_off, a_first, a_last, a_pcw} !== {1'b1, 3'd1, 4'd0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL stall_held got %b want 10010000100",
                     {a_valid, a_reg, a_off, a_first, a_last, a_pcw});
        end
        next_cycle();
        ir_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_valid, a_reg, a_off, a_first, a_last, a_pcw} !== {1'b1, 3'd2, 4'd1, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL stall_resume got %b want 10100010011",
                     {a_valid, a_reg, a_off, a_first, a_last, a_pcw});
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({a_valid, a_busy} !== 2'b00) begin
            failures++;
            $display("FAIL stall_end got %b want 00", {a_valid, a_busy});
        end
    endtask

    task automatic test_flush();
        logic [15:0] got, exp;
        next_cycle();
        ir_in = 16'h60FF; ir_valid = 1'b1;
        for (int k = 1; k <= 4; k++) next_cycle();
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_valid, a_reg, a_off} !== {1'b1, 3'd3, 4'd3}) begin
            failures++;
            $display("FAIL flush_pre got %b want 10110011", {a_valid, a_reg, a_off});
        end
        next_cycle();
        flush = 1'b0; ir_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_valid, a_busy, a_pcw, a_hold, b_valid, b_busy} !== 6'b001000) begin
            failures++;
            $display("FAIL flush_after got %b want 001000", {a_valid, a_busy, a_pcw, a_hold, b_valid, b_busy});
        end
        next_cycle();
        ir_in = 16'h6001; ir_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (a_pcw !== 1'b1) begin
            failures++;
            $display("FAIL flush_single_pc got %b want 1", a_pcw);
        end
        next_cycle();
        ir_valid = 1'b0;
        @(negedge clk);
        got = pack(a_valid, a_reg, a_off, a_first, a_last, a_store, a_base, a_pcw, a_busy);
        exp = pack(1'b1, 3'd0, 4'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL flush_single_uop got %h want %h", got, exp);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({a_valid, a_busy} !== 2'b00) begin
            failures++;
            $display("FAIL flush_single_end got %b want 00", {a_valid, a_busy});
        end
    endtask

    task automatic test_async_reset();
        next_cycle();
        ir_in = 16'h60FF; ir_valid = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({a_valid, a_reg} !== {1'b1, 3'd1}) begin
            failures++;
            $display("FAIL areset_pre got %b want 1001", {a_valid, a_reg});
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({a_valid, a_reg, a_off, a_first, a_busy, a_pcw, a_hold, b_valid, b_busy, b_pcw}
                !== {1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL areset_now got %b want 000000000010001",
                     {a_valid, a_reg, a_off, a_first, a_busy, a_pcw, a_hold, b_valid, b_busy, b_pcw});
        end
        next_cycle();
        reset = 1'b0; ir_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_valid, a_busy, a_pcw} !== 3'b001) begin
            failures++;
            $display("FAIL areset_after got %b want 001", {a_valid, a_busy, a_pcw});
        end
    endtask

    initial begin
        test_reset();
        test_lm_ascending();
        test_sm_descending();
        test_empty_mask();
        test_back_to_back();
        test_stall();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
